// File: rtl/reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_sequencer
// Purpose  : Register-bus initiator. Queues copy/clear commands and plays them
//            out as two-phase oa/wa/clr strobe sequences on the shared bus.
//            Optional xfer_cnt output enabled by macro REG_BUS_XFER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_sequencer #(
    parameter int NREG  = 8,
    parameter int IDXW  = 3,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [IDXW-1:0] req_src,
    input  logic [IDXW-1:0] req_dst,
    input  logic            req_clr,
    output logic [NREG-1:0] oa,
    output logic [NREG-1:0] wa,
    output logic [NREG-1:0] clr,
    output logic            busy,
    output logic            done
`ifdef REG_BUS_XFER_CNT_EN
    ,
    output logic [7:0]      xfer_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   c_full = DEPTH[CW-1:0];
    localparam logic [IDXW:0]   c_nreg = NREG[IDXW:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    logic [IDXW-1:0] r_mem_src [DEPTH];
    logic [IDXW-1:0] r_mem_dst [DEPTH];
    logic            r_mem_clr [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    state_t          r_state;
    logic [IDXW-1:0] r_dst;
    logic [NREG-1:0] r_oa;
    logic [NREG-1:0] r_wa;
    logic [NREG-1:0] r_clr;
    logic            r_done;
`ifdef REG_BUS_XFER_CNT_EN
    logic [7:0]      r_xfer_cnt;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [IDXW-1:0] w_head_src;
    logic [IDXW-1:0] w_head_dst;
    logic            w_head_clr;
    logic            w_head_noop;

    function automatic logic f_in_range(input logic [IDXW-1:0] idx);
        return {1'b0, idx} < c_nreg;
    endfunction

    function automatic logic [NREG-1:0] f_onehot(input logic [IDXW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = ({1'b0, idx} == i[IDXW:0]);
        end
        return v;
    endfunction

    assign w_empty     = (r_count == '0);
    assign req_ready   = (r_count != c_full);
    assign w_push      = req_valid && req_ready;
    assign w_head_src  = r_mem_src[r_rd_ptr];
    assign w_head_dst  = r_mem_dst[r_rd_ptr];
    assign w_head_clr  = r_mem_clr[r_rd_ptr];
    assign w_head_noop = w_head_clr ? !f_in_range(w_head_dst)
                                    : (!f_in_range(w_head_src) || !f_in_range(w_head_dst)
                                       || (w_head_src == w_head_dst));
    // A no-op reached from XFER is left for IDLE so each retire gets its own done cycle.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                                      ((r_state == ST_XFER) && !w_head_noop));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_src[r_wr_ptr] <= req_src;
            r_mem_dst[r_wr_ptr] <= req_dst;
            r_mem_clr[r_wr_ptr] <= req_clr;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_dst   <= '0;
            r_oa    <= '0;
            r_wa    <= '0;
            r_clr   <= '0;
            r_done  <= 1'b0;
`ifdef REG_BUS_XFER_CNT_EN
            r_xfer_cnt <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_oa  <= '0;
                    r_wa  <= '0;
                    r_clr <= '0;
                end
                ST_SETUP: begin
                    r_wa    <= f_onehot(r_dst);
                    r_state <= ST_XFER;
                end
                ST_XFER: begin
                    r_oa    <= '0;
                    r_wa    <= '0;
                    r_clr   <= '0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
`ifdef REG_BUS_XFER_CNT_EN
                    r_xfer_cnt <= r_xfer_cnt + 8'd1;
`endif
                end
                default: begin
                    r_oa    <= '0;
                    r_wa    <= '0;
                    r_clr   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase

            // Launching the next command overrides the idle defaults set above.
            if (w_pop) begin
                r_dst <= w_head_dst;
                if (w_head_noop) begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end else if (w_head_clr) begin
                    r_clr   <= f_onehot(w_head_dst);
                    r_state <= ST_XFER;
                end else begin
                    r_oa    <= f_onehot(w_head_src);
                    r_state <= ST_SETUP;
                end
            end
        end
    end

    assign oa   = r_oa;
    assign wa   = r_wa;
    assign clr  = r_clr;
    assign done = r_done;
    assign busy = (r_state != ST_IDLE) || !w_empty;
`ifdef REG_BUS_XFER_CNT_EN
    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bus_sequencer
// Purpose  : Scoreboard bench for reg_bus_sequencer with an attached register
//            file model; xfer_cnt checks enabled by REG_BUS_XFER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bus_sequencer;

    localparam int NREG  = 8;
    localparam int IDXW  = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [IDXW-1:0] req_src = '0;
    logic [IDXW-1:0] req_dst = '0;
    logic            req_clr = 1'b0;
    logic [NREG-1:0] oa, wa, clr;
    logic            busy, done;
`ifdef REG_BUS_XFER_CNT_EN
    logic [7:0]      xfer_cnt;
    logic [7:0]      cnt_before;
`endif

    reg_bus_sequencer #(.NREG(NREG), .IDXW(IDXW), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_clr   (req_clr),
        .oa        (oa),
        .wa        (wa),
        .clr       (clr),
        .busy      (busy),
        .done      (done)
`ifdef REG_BUS_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            noop;
        logic            isclr;
        logic [IDXW-1:0] src;
        logic [IDXW-1:0] dst;
        logic [7:0]      val;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         oa_cyc = 0;
    int         st_cyc = 0;
    logic [7:0] regs   [NREG];
    logic [7:0] shadow [NREG];
    logic [7:0] bus_val;
    logic       load_model = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] exp_onehot(input logic [IDXW-1:0] idx);
        logic [NREG-1:0] one;
        one = 1;
        return (int'(idx) < NREG) ? (one << idx) : '0;
    endfunction

    // Registers hanging off the bus: drive on oa, latch bus on wa, zero on clr.
    always_comb begin
        bus_val = '0;
        for (int i = 0; i < NREG; i++) if (oa[i]) bus_val = bus_val | regs[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (load_model)  regs[i] <= 8'(17 * (i + 1));
            else if (clr[i]) regs[i] <= 8'h00;
            else if (wa[i])  regs[i] <= bus_val;
        end
    end

    always @(negedge clk) begin
        if (!clr_n) begin
            oa_cyc = 0;
            st_cyc = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("retire_strobe_cycles", st_cyc, e.noop ? 0 : 1);
                    check("retire_oa_cycles", oa_cyc, (e.noop || e.isclr) ? 0 : 2);
                    if (!e.noop) check("dst_value", regs[e.dst], e.val);
                end
                oa_cyc = 0;
                st_cyc = 0;
            end
            if ((oa | wa | clr) != '0) begin
                check("inv_onehot", ($countones(oa) <= 1) && ($countones(wa) <= 1)
                                    && ($countones(clr) <= 1), 1);
                check("inv_wa_clr", (wa != '0) && (clr != '0), 0);
                check("inv_oa_wa", oa & wa, 0);
                if (sb.size() == 0) begin
                    check("strobe_no_cmd", 1, 0);
                end else if (sb[0].noop) begin
                    check("noop_strobe", oa | wa | clr, 0);
                end else if (sb[0].isclr) begin
                    check("clr_vec", clr, exp_onehot(sb[0].dst));
                    check("clr_oa", oa | wa, 0);
                end else begin
                    check("copy_oa", oa, exp_onehot(sb[0].src));
                    check("copy_wa", wa, (oa_cyc == 0) ? '0 : exp_onehot(sb[0].dst));
                    check("copy_clr", clr, 0);
                end
                if (oa != '0) oa_cyc++;
                if ((wa | clr) != '0) st_cyc++;
            end
        end
    end

    task automatic push(input logic c, input int s, input int d, output int waited);
        exp_t e;
        int   w;
        w = 0;
        req_valid = 1'b1;
        req_clr   = c;
        req_src   = IDXW'(s);
        req_dst   = IDXW'(d);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            check("push_timeout", 0, 1);
        end else begin
            @(posedge clk);
            e.isclr = c;
            e.src   = IDXW'(s);
            e.dst   = IDXW'(d);
            e.noop  = c ? !(d < NREG) : (!(s < NREG) || !(d < NREG) || (s == d));
            e.val   = (c || !(s < NREG)) ? 8'h00 : shadow[s];
            if (!e.noop) shadow[d] = e.val;
            sb.push_back(e);
            @(negedge clk);
        end
        req_valid = 1'b0;
        waited = w;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 300, 1);
    endtask

    task automatic do_reset();
        int nd;
        #2 clr_n = 1'b0;
        #1;
        check("rst_strobes", {oa, wa, clr}, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        sb.delete();
        for (int i = 0; i < NREG; i++) shadow[i] = regs[i];
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        nd = 0;
        repeat (4) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("rst_no_done", nd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int nd;
        for (int i = 0; i < NREG; i++) shadow[i] = 8'(17 * (i + 1));
        repeat (2) @(negedge clk);
        check("boot_strobes", {oa, wa, clr}, 0);
        check("boot_done_busy", {done, busy}, 0);
        load_model = 1'b0;
        clr_n = 1'b1;
        @(negedge clk);
        check("boot_ready", req_ready, 1);

        // Single copy 2 -> 5: cycle-exact latency
        push(1'b0, 2, 5, w);
        check("lat_n0_oa", oa, 0);
        @(negedge clk);
        check("lat_setup_oa", oa, 8'h04);
        check("lat_setup_wa", wa, 8'h00);
        @(negedge clk);
        check("lat_xfer_oa", oa, 8'h04);
        check("lat_xfer_wa", wa, 8'h20);
        check("lat_xfer_done", done, 0);
        @(negedge clk);
        check("lat_done", done, 1);
        check("lat_idle_strobes", {oa, wa}, 0);
        check("lat_reg5", regs[5], 8'h33);
        @(negedge clk);
        check("lat_done_drop", done, 0);
        wait_idle();

        // Clear 7 followed directly by copy 1 -> 3
        push(1'b1, 0, 7, w);
        check("cc_pre_clr", clr, 0);
        push(1'b0, 1, 3, w);
        check("cc_clr", clr, 8'h80);
        check("cc_done0", done, 0);
        @(negedge clk);
        check("cc_clr_gone", clr, 0);
        check("cc_setup_oa", oa, 8'h02);
        check("cc_done1", done, 1);
        @(negedge clk);
        check("cc_gap", done, 0);
        check("cc_wa", wa, 8'h08);
        @(negedge clk);
        check("cc_done2", done, 1);
        wait_idle();

        // Fill the FIFO with back-to-back copies, then one more
        for (int i = 0; i < 7; i++) push(1'b0, i, (i + 3) % NREG, w);
        check("full_ready", req_ready, 0);
        push(1'b0, 6, 0, w);
        check("full_wait", w, 1);
        wait_idle();

        // No-op and out-of-range commands
`ifdef REG_BUS_XFER_CNT_EN
        cnt_before = xfer_cnt;
`endif
        push(1'b0, 4, 4, w);
        push(1'b0, 1, 9, w);
        nd = 0;
        repeat (4) begin
            check("noop_quiet", {oa, wa, clr}, 0);
            if (done) nd++;
            @(negedge clk);
        end
        check("noop_done_cnt", nd, 2);
`ifdef REG_BUS_XFER_CNT_EN
        check("noop_xfer_cnt", xfer_cnt, cnt_before);
`endif
        wait_idle();

        // Reset while in XFER with three commands queued
        for (int i = 0; i < 5; i++) push(1'b0, i + 1, i, w);
        check("pre_reset_xfer", wa != '0, 1);
        do_reset();

        // 257 back-to-back clears
        for (int i = 0; i < 257; i++) push(1'b1, 0, i % NREG, w);
        wait_idle();
`ifdef REG_BUS_XFER_CNT_EN
        check("xfer_cnt_wrap", xfer_cnt, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
